branch_res_queue: RTL and testbench

- Tracks every prediction the BPU hands to fetch until the branch unit resolves it.
- Compares the predicted outcome against the actual one and produces the `resolution_t` stream that feeds the BPU's update port (`bu_res_valid_i` / `bu_res_i`).
- Sits between fetch/issue (allocation side) and the branch unit (resolution side).
- Owns the in-flight prediction storage and the mispredict decision.

---
 rtl/branch_res_queue_pkg.sv | 39 +++
 rtl/branch_res_queue.sv | 85 ++++++++
 tb/tb_branch_res_queue.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_res_queue_pkg.sv
// Shared types for the branch resolution queue:
// prediction/resolution records and the queue entry.
package branch_res_queue_pkg;

   localparam int XLEN = 64;
   localparam int BRQ_DEPTH = 8;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic            hit;
      logic            taken;
      logic [XLEN-1:0] target;
   } prediction_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] target;
      logic            taken;
      logic            mispredict;
   } resolution_t;

   typedef struct packed {
      logic        valid;
      logic        resolved;
      prediction_t pred;
   } brq_entry_t;

   // A BTB miss counts as a not-taken prediction.
   function automatic logic pred_mispredict(
      prediction_t     p,
      logic            taken,
      logic [XLEN-1:0] target
   );
      logic pt;
      pt = p.hit & p.taken;
      return (pt != taken) | (taken & pt & (p.target != target));
   endfunction

endpackage

// File: rtl/branch_res_queue.sv
// In-flight prediction tracker: allocates on fetch, resolves from
// the branch unit, emits BPU updates and retires in program order.
module branch_res_queue
   import branch_res_queue_pkg::*;
#(
   parameter int DEPTH = BRQ_DEPTH,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              pred_valid_i,
   output logic              pred_ready_o,
   input  prediction_t       pred_i,
   output logic [TAG_W-1:0]  pred_tag_o,
   input  logic              bu_valid_i,
   input  logic [TAG_W-1:0]  bu_tag_i,
   input  logic              bu_taken_i,
   input  logic [XLEN-1:0]   bu_target_i,
   output logic              res_valid_o,
   output resolution_t       res_o,
   output logic              empty_o,
   output logic [TAG_W:0]    count_o
);

   brq_entry_t       q [DEPTH];
   logic [TAG_W-1:0] head;
   logic [TAG_W-1:0] tail;
   logic [TAG_W:0]   count;

   logic push;
   logic resolve;
   logic retire;

   assign pred_ready_o = (count != (TAG_W+1)'(DEPTH));
   assign pred_tag_o   = tail;
   assign empty_o      = (count == '0);
   assign count_o      = count;

   assign push    = pred_valid_i & pred_ready_o;
   assign resolve = bu_valid_i & q[bu_tag_i].valid
                  & ~q[bu_tag_i].resolved;
   // Uses the registered resolved bit, so a branch resolved this
   // cycle can only retire from the next cycle on.
   assign retire  = q[head].valid & q[head].resolved;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         res_valid_o <= 1'b0;
         res_o       <= '0;
      end else if (flush_i) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         res_valid_o <= 1'b0;
      end else begin
         if (push) begin
            q[tail] <= '{valid: 1'b1, resolved: 1'b0, pred: pred_i};
            tail    <= tail + 1'b1;
         end
         if (resolve) begin
            q[bu_tag_i].resolved <= 1'b1;
            res_o.pc         <= q[bu_tag_i].pred.pc;
            res_o.taken      <= bu_taken_i;
            res_o.target     <= bu_target_i;
            res_o.mispredict <= pred_mispredict(q[bu_tag_i].pred,
                                                bu_taken_i,
                                                bu_target_i);
         end
         res_valid_o <= resolve;
         if (retire) begin
            q[head].valid    <= 1'b0;
            q[head].resolved <= 1'b0;
            head             <= head + 1'b1;
         end
         count <= count + (TAG_W+1)'(push) - (TAG_W+1)'(retire);
      end
   end

endmodule

// File: tb/tb_branch_res_queue.sv
// Bench for branch_res_queue (DEPTH=4): directed vector table,
// then random traffic against a program-order queue model.
module tb_branch_res_queue;
   import branch_res_queue_pkg::*;

   localparam int D  = 4;
   localparam int TW = 2;

   logic              clk = 1'b0;
   logic              rst_i, flush_i;
   logic              pred_valid_i, pred_ready_o;
   prediction_t       pred_i;
   logic [TW-1:0]     pred_tag_o;
   logic              bu_valid_i;
   logic [TW-1:0]     bu_tag_i;
   logic              bu_taken_i;
   logic [XLEN-1:0]   bu_target_i;
   logic              res_valid_o;
   resolution_t       res_o;
   logic              empty_o;
   logic [TW:0]       count_o;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   branch_res_queue #(.DEPTH(D), .TAG_W(TW)) dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
      .pred_valid_i(pred_valid_i), .pred_ready_o(pred_ready_o),
      .pred_i(pred_i), .pred_tag_o(pred_tag_o),
      .bu_valid_i(bu_valid_i), .bu_tag_i(bu_tag_i),
      .bu_taken_i(bu_taken_i), .bu_target_i(bu_target_i),
      .res_valid_o(res_valid_o), .res_o(res_o),
      .empty_o(empty_o), .count_o(count_o)
   );

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Mispredict from first principles: where did fetch go vs.
   // where the branch really went.
   function automatic logic ref_mis(prediction_t p, logic tk,
                                    logic [63:0] tg);
      if (!(p.hit && p.taken)) return tk;
      if (!tk) return 1'b1;
      return p.target != tg;
   endfunction

   typedef struct {
      logic        pv;
      logic [63:0] pc;
      logic        hit, tk;
      logic [63:0] tgt;
      logic        bv;
      logic [1:0]  btag;
      logic        btk;
      logic [63:0] btgt;
      logic        fl;
      logic        ex_ready;
      logic [1:0]  ex_tag;
      logic        ex_rv;
      logic [63:0] ex_pc;
      logic        ex_tk;
      logic [63:0] ex_tgt;
      logic        ex_mis;
      logic [2:0]  ex_cnt;
   } vec_t;

   vec_t vt[$];

   task automatic add(
      logic pv, logic [63:0] pc, logic hit, logic tk, logic [63:0] tgt,
      logic bv, logic [1:0] btag, logic btk, logic [63:0] btgt,
      logic fl, logic er, logic [1:0] et, logic erv,
      logic [63:0] epc, logic etk, logic [63:0] etg, logic emis,
      logic [2:0] ecnt);
      vec_t v;
      v.pv = pv; v.pc = pc; v.hit = hit; v.tk = tk; v.tgt = tgt;
      v.bv = bv; v.btag = btag; v.btk = btk; v.btgt = btgt;
      v.fl = fl; v.ex_ready = er; v.ex_tag = et; v.ex_rv = erv;
      v.ex_pc = epc; v.ex_tk = etk; v.ex_tgt = etg; v.ex_mis = emis;
      v.ex_cnt = ecnt;
      vt.push_back(v);
   endtask

   task automatic idle_inputs();
      rst_i = 0; flush_i = 0; pred_valid_i = 0; pred_i = '0;
      bu_valid_i = 0; bu_tag_i = '0; bu_taken_i = 0; bu_target_i = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1;
      @(posedge clk); #1;
      rst_i = 0;
   endtask

   // Reference model: live predictions in program order.
   typedef struct {
      logic [1:0]  tag;
      prediction_t p;
      bit          done;
   } mrec_t;
   mrec_t       mq[$];
   int unsigned m_next;

   task automatic rnd_cycle();
      logic        rv;
      logic [63:0] epc, etg;
      logic        etk, emis;
      bit          pop, psh;
      int          idx;
      pred_valid_i = ($urandom_range(0, 9) < 6);
      pred_i.pc     = 64'(($urandom_range(0, 4095)) << 2);
      pred_i.hit    = 1'($urandom);
      pred_i.taken  = 1'($urandom);
      pred_i.target = $urandom_range(0, 1) ? 64'h100 : 64'h200;
      bu_valid_i  = 1'($urandom);
      bu_tag_i    = 2'($urandom);
      bu_taken_i  = 1'($urandom);
      bu_target_i = $urandom_range(0, 1) ? 64'h100 : 64'h200;
      flush_i     = ($urandom_range(0, 99) < 3);
      chk("rnd_ready", 64'(pred_ready_o), 64'(mq.size() != D));
      chk("rnd_tag", 64'(pred_tag_o), 64'(m_next % D));
      rv = 0; epc = 0; etk = 0; etg = 0; emis = 0;
      if (flush_i) begin
         mq.delete();
         m_next = 0;
      end else begin
         psh = pred_valid_i && (mq.size() != D);
         pop = (mq.size() != 0) && mq[0].done;
         idx = -1;
         foreach (mq[i]) if (mq[i].tag == bu_tag_i) idx = i;
         if (bu_valid_i && idx >= 0 && !mq[idx].done) begin
            mq[idx].done = 1;
            rv   = 1;
            epc  = mq[idx].p.pc;
            etk  = bu_taken_i;
            etg  = bu_target_i;
            emis = ref_mis(mq[idx].p, bu_taken_i, bu_target_i);
         end
         if (pop) void'(mq.pop_front());
         if (psh) begin
            mrec_t r;
            r.tag = 2'(m_next % D); r.p = pred_i; r.done = 0;
            mq.push_back(r);
            m_next++;
         end
      end
      @(posedge clk); #1;
      chk("rnd_res_valid", 64'(res_valid_o), 64'(rv));
      if (rv) begin
         chk("rnd_res_pc", res_o.pc, epc);
         chk("rnd_res_taken", 64'(res_o.taken), 64'(etk));
         chk("rnd_res_target", res_o.target, etg);
         chk("rnd_res_mis", 64'(res_o.mispredict), 64'(emis));
      end
      chk("rnd_count", 64'(count_o), 64'(mq.size()));
      chk("rnd_empty", 64'(empty_o), 64'(mq.size() == 0));
   endtask

   initial begin
      idle_inputs();
      @(posedge clk); #1;
      do_reset();
      chk("reset_res_valid", 64'(res_valid_o), 0);
      chk("reset_ready", 64'(pred_ready_o), 1);
      chk("reset_empty", 64'(empty_o), 1);
      chk("reset_count", 64'(count_o), 0);
      chk("reset_tag", 64'(pred_tag_o), 0);
      chk("reset_res", 64'(res_o.pc), 0);

      // pv pc hit tk tgt | bv tag tk tgt | fl | rdy tag | rv pc tk tgt mis | cnt
      add(1,'h1000,1,1,'h1040, 0,0,0,0,      0, 1,0, 0,0,0,0,0,            1);
      add(0,0,0,0,0,           1,0,1,'h1040, 0, 1,1, 1,'h1000,1,'h1040,0,  1);
      add(0,0,0,0,0,           0,0,0,0,      0, 1,1, 0,0,0,0,0,            0);
      add(1,'h1000,1,1,'h1040, 0,0,0,0,      0, 1,1, 0,0,0,0,0,            1);
      add(0,0,0,0,0,           1,1,1,'h1080, 0, 1,2, 1,'h1000,1,'h1080,1,  1);
      add(1,'h2000,0,1,'h2040, 0,0,0,0,      0, 1,2, 0,0,0,0,0,            1);
      add(0,0,0,0,0,           1,2,0,'h2004, 0, 1,3, 1,'h2000,0,'h2004,0,  1);
      add(1,'h2000,0,1,'h2040, 0,0,0,0,      0, 1,3, 0,0,0,0,0,            1);
      add(0,0,0,0,0,           1,3,1,'h2040, 0, 1,0, 1,'h2000,1,'h2040,1,  1);
      add(0,0,0,0,0,           0,0,0,0,      0, 1,0, 0,0,0,0,0,            0);
      add(1,'h3000,1,0,0,      0,0,0,0,      0, 1,0, 0,0,0,0,0,            1);
      add(1,'h3010,1,0,0,      0,0,0,0,      0, 1,1, 0,0,0,0,0,            2);
      add(1,'h3020,1,0,0,      0,0,0,0,      0, 1,2, 0,0,0,0,0,            3);
      add(1,'h3030,1,0,0,      0,0,0,0,      0, 1,3, 0,0,0,0,0,            4);
      add(1,'h3999,1,0,0,      0,0,0,0,      0, 0,0, 0,0,0,0,0,            4);
      add(0,0,0,0,0,           1,2,0,'h9,    0, 0,0, 1,'h3020,0,'h9,0,     4);
      add(0,0,0,0,0,           1,0,0,'h9,    0, 0,0, 1,'h3000,0,'h9,0,     4);
      add(0,0,0,0,0,           0,0,0,0,      0, 0,0, 0,0,0,0,0,            3);
      add(1,'h3040,1,0,0,      0,0,0,0,      0, 1,0, 0,0,0,0,0,            4);
      add(0,0,0,0,0,           1,2,1,'h9,    0, 0,1, 0,0,0,0,0,            4);
      add(0,0,0,0,0,           1,1,1,'h5,    0, 0,1, 1,'h3010,1,'h5,1,     4);
      add(0,0,0,0,0,           0,0,0,0,      0, 0,1, 0,0,0,0,0,            3);
      add(0,0,0,0,0,           0,0,0,0,      0, 1,1, 0,0,0,0,0,            2);
      add(0,0,0,0,0,           0,0,0,0,      0, 1,1, 0,0,0,0,0,            2);
      add(0,0,0,0,0,           1,1,1,'h5,    0, 1,1, 0,0,0,0,0,            2);
      add(1,'h4000,1,1,'h4400, 0,0,0,0,      0, 1,1, 0,0,0,0,0,            3);
      add(1,'h5000,1,1,'h5400, 1,3,0,'h7,    1, 1,2, 0,0,0,0,0,            0);
      add(1,'h6000,1,1,'h6400, 0,0,0,0,      0, 1,0, 0,0,0,0,0,            1);

      foreach (vt[i]) begin
         pred_valid_i  = vt[i].pv;
         pred_i.pc     = vt[i].pc;
         pred_i.hit    = vt[i].hit;
         pred_i.taken  = vt[i].tk;
         pred_i.target = vt[i].tgt;
         bu_valid_i    = vt[i].bv;
         bu_tag_i      = vt[i].btag;
         bu_taken_i    = vt[i].btk;
         bu_target_i   = vt[i].btgt;
         flush_i       = vt[i].fl;
         chk($sformatf("v%0d_ready", i), 64'(pred_ready_o),
             64'(vt[i].ex_ready));
         if (vt[i].ex_ready)
            chk($sformatf("v%0d_tag", i), 64'(pred_tag_o),
                64'(vt[i].ex_tag));
         @(posedge clk); #1;
         chk($sformatf("v%0d_res_valid", i), 64'(res_valid_o),
             64'(vt[i].ex_rv));
         if (vt[i].ex_rv) begin
            chk($sformatf("v%0d_pc", i), res_o.pc, vt[i].ex_pc);
            chk($sformatf("v%0d_taken", i), 64'(res_o.taken),
                64'(vt[i].ex_tk));
            chk($sformatf("v%0d_target", i), res_o.target,
                vt[i].ex_tgt);
            chk($sformatf("v%0d_mis", i), 64'(res_o.mispredict),
                64'(vt[i].ex_mis));
         end
         chk($sformatf("v%0d_count", i), 64'(count_o),
             64'(vt[i].ex_cnt));
         chk($sformatf("v%0d_empty", i), 64'(empty_o),
             64'(vt[i].ex_cnt == 0));
      end

      // Reset must also override a concurrent flush.
      idle_inputs();
      flush_i = 1;
      rst_i   = 1;
      @(posedge clk); #1;
      idle_inputs();
      chk("rst_over_flush_count", 64'(count_o), 0);
      chk("rst_over_flush_res", 64'(res_o.pc), 0);

      mq.delete();
      m_next = 0;
      for (int n = 0; n < 1500; n++) rnd_cycle();

      idle_inputs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
